// File: rtl/noc_pkg.sv
// Purpose: shared flit format and packetizer state encoding for the leaf network interface.
// Latency: none (type and constant definitions only).
// Backpressure: n/a.
package noc_pkg;

    localparam int FLIT_W   = 9;
    localparam int TAIL_BIT = 8;

    // Bit 8 marks the last flit of a packet; bits 7:0 are header address or payload.
    typedef struct packed {
        logic       tail;
        logic [7:0] data;
    } flit_t;

    typedef enum logic {
        IDLE = 1'b0,
        BODY = 1'b1
    } pkt_state_e;

    function automatic flit_t make_flit(input logic tail, input logic [7:0] data);
        flit_t f;
        f.tail = tail;
        f.data = data;
        return f;
    endfunction

endpackage

// File: rtl/noc_flit_fifo.sv
// Purpose: synchronous flit FIFO with wrap-bit pointers; shared by packetizer and depacketizer.
// Latency: a flit written on edge N is visible on rd_data after that edge (no fall-through bypass).
// Backpressure: writes are dropped while full, reads ignored while empty; full/empty come from registered pointers.
// Ports: CLK/RESET (async, active-high); wr_en/wr_data/full on the write side;
//        rd_en/rd_data/empty on the read side, rd_data showing the current head.
module noc_flit_fifo
    import noc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  CLK,
    input  logic  RESET,
    input  logic  wr_en,
    input  flit_t wr_data,
    output logic  full,
    input  logic  rd_en,
    output flit_t rd_data,
    output logic  empty
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    flit_t       r_mem [DEPTH];

    logic w_wr_fire;
    logic w_rd_fire;

    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign empty = (r_wr_ptr == r_rd_ptr);

    assign w_wr_fire = wr_en && !full;
    assign w_rd_fire = rd_en && !empty;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_fire) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_fire) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: an entry is only observable after it has been written.
    always_ff @(posedge CLK) begin
        if (w_wr_fire) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/noc_leaf_packetizer.sv
// Purpose: turns core packet requests plus payload bytes into a header/payload/tail flit stream for a leaf router.
// Latency: a flit written in cycle N is offered on flit_data in cycle N+1 at the earliest; one flit per cycle sustained.
// Backpressure: req_ready/pay_ready follow only the registered FIFO-full flag, never flit_ready directly.
// Ports: CLK/RESET (async, active-high); req_valid/req_ready/req_dest/req_len request channel;
//        pay_valid/pay_ready/pay_data payload channel; flit_valid/flit_ready/flit_data output stream;
//        busy (packet in progress or flits queued); pkt_count (tails delivered, wraps at 16 bits).
module noc_leaf_packetizer
    import noc_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 4,
    parameter int ADDR_W     = 8   // at most 8; zero-extended into the header byte
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_dest,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              pay_valid,
    output logic              pay_ready,
    input  logic [7:0]        pay_data,
    output logic              flit_valid,
    input  logic              flit_ready,
    output logic [FLIT_W-1:0] flit_data,
    output logic              busy,
    output logic [15:0]       pkt_count
);

    pkt_state_e       r_state;
    pkt_state_e       w_next_state;
    logic [LEN_W-1:0] r_remaining;
    logic [15:0]      r_pkt_count;

    logic       w_req_rdy;
    logic       w_pay_rdy;
    logic       w_req_fire;
    logic       w_pay_fire;
    logic       w_wr_en;
    flit_t      w_wr_flit;
    logic       w_fifo_full;
    logic       w_fifo_empty;
    logic       w_rd_en;
    flit_t      w_rd_flit;
    logic       w_flit_vld;
    logic [7:0] w_dest_ext;

    assign w_dest_ext = 8'(req_dest);
    assign w_req_fire = req_valid && w_req_rdy;
    assign w_pay_fire = pay_valid && w_pay_rdy;

    // State register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    // Next-state logic: a zero-length request is a complete packet and never leaves IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (w_req_fire && (req_len != '0)) w_next_state = BODY;
            BODY: if (w_pay_fire && (r_remaining == LEN_W'(1))) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Output logic: handshakes and the flit written into the FIFO this cycle.
    always_comb begin
        w_req_rdy = 1'b0;
        w_pay_rdy = 1'b0;
        w_wr_en   = 1'b0;
        w_wr_flit = '0;
        case (r_state)
            IDLE: begin
                w_req_rdy = !w_fifo_full;
                if (req_valid && !w_fifo_full) begin
                    w_wr_en   = 1'b1;
                    w_wr_flit = make_flit(req_len == '0, w_dest_ext);
                end
            end
            BODY: begin
                w_pay_rdy = !w_fifo_full;
                if (pay_valid && !w_fifo_full) begin
                    w_wr_en   = 1'b1;
                    w_wr_flit = make_flit(r_remaining == LEN_W'(1), pay_data);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_remaining <= '0;
        end else if (w_req_fire) begin
            r_remaining <= req_len;
        end else if (w_pay_fire) begin
            r_remaining <= r_remaining - LEN_W'(1);
        end
    end

    noc_flit_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RESET   (RESET),
        .wr_en   (w_wr_en),
        .wr_data (w_wr_flit),
        .full    (w_fifo_full),
        .rd_en   (w_rd_en),
        .rd_data (w_rd_flit),
        .empty   (w_fifo_empty)
    );

    assign w_flit_vld = !RESET && !w_fifo_empty;
    assign w_rd_en    = w_flit_vld && flit_ready;

    // A packet is counted when its tail actually leaves toward the router.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_pkt_count <= '0;
        end else if (w_rd_en && w_rd_flit.tail) begin
            r_pkt_count <= r_pkt_count + 16'd1;
        end
    end

    // Outputs are forced low while RESET is held; flit_data is also zero when nothing is queued.
    assign req_ready  = !RESET && w_req_rdy;
    assign pay_ready  = !RESET && w_pay_rdy;
    assign flit_valid = w_flit_vld;
    assign flit_data  = w_flit_vld ? w_rd_flit : '0;
    assign busy       = !RESET && ((r_state != IDLE) || !w_fifo_empty);
    assign pkt_count  = r_pkt_count;

endmodule

// File: tb/tb_noc_leaf_packetizer.sv
// Purpose: directed self-checking bench for noc_leaf_packetizer.
// Latency: n/a.
// Backpressure: flit_ready is driven per scenario; all waits on the DUT are cycle-bounded.
module tb_noc_leaf_packetizer;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_dest;
    logic [3:0]  req_len;
    logic        pay_valid;
    logic        pay_ready;
    logic [7:0]  pay_data;
    logic        flit_valid;
    logic        flit_ready;
    logic [8:0]  flit_data;
    logic        busy;
    logic [15:0] pkt_count;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int w;

    logic [8:0] got_q [$];
    int         cyc_q [$];
    logic [8:0] exp_q [$];

    noc_leaf_packetizer #(
        .FIFO_DEPTH (4),
        .LEN_W      (4),
        .ADDR_W     (8)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_dest   (req_dest),
        .req_len    (req_len),
        .pay_valid  (pay_valid),
        .pay_ready  (pay_ready),
        .pay_data   (pay_data),
        .flit_valid (flit_valid),
        .flit_ready (flit_ready),
        .flit_data  (flit_data),
        .busy       (busy),
        .pkt_count  (pkt_count)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // flit_ready only changes just after a rising edge, so a negedge sample predicts the next transfer.
    always @(negedge CLK) begin
        if (!RESET && flit_valid && flit_ready) begin
            got_q.push_back(flit_data);
            cyc_q.push_back(cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        n_checks++;
        n_err++;
        $error("FAIL %s: observed no handshake, expected one within 50 cycles", tag);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_req(input logic [7:0] d, input logic [3:0] l, output int waited);
        bit done = 0;
        req_valid = 1'b1;
        req_dest  = d;
        req_len   = l;
        waited    = 0;
        while (!done) begin
            @(negedge CLK);
            if (req_ready) done = 1;
            else begin
                waited++;
                if (waited > 50) begin
                    timeout_fail("req_handshake");
                    done = 1;
                end
            end
        end
        tick();
        req_valid = 1'b0;
    endtask

    task automatic send_pay(input logic [7:0] d, output int waited);
        bit done = 0;
        pay_valid = 1'b1;
        pay_data  = d;
        waited    = 0;
        while (!done) begin
            @(negedge CLK);
            if (pay_ready) done = 1;
            else begin
                waited++;
                if (waited > 50) begin
                    timeout_fail("pay_handshake");
                    done = 1;
                end
            end
        end
        tick();
        pay_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (busy && n < 100);
        if (busy) timeout_fail(tag);
    endtask

    task automatic check_stream(input string tag);
        check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        foreach (exp_q[i]) begin
            check($sformatf("%s_%0d", tag, i),
                  (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD_BEEF,
                  32'(exp_q[i]));
        end
    endtask

    initial begin
        RESET      = 1'b1;
        req_valid  = 1'b0;
        req_dest   = 8'h00;
        req_len    = 4'h0;
        pay_valid  = 1'b0;
        pay_data   = 8'h00;
        flit_ready = 1'b0;

        // Reset state
        #2;
        check("rst_req_ready",  32'(req_ready),  32'd0);
        check("rst_pay_ready",  32'(pay_ready),  32'd0);
        check("rst_flit_valid", 32'(flit_valid), 32'd0);
        check("rst_flit_data",  32'(flit_data),  32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_pkt_count",  32'(pkt_count),  32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        tick();
        @(negedge CLK);
        check("idle_req_ready",  32'(req_ready),  32'd1);
        check("idle_pay_ready",  32'(pay_ready),  32'd0);
        check("idle_flit_valid", 32'(flit_valid), 32'd0);
        check("idle_busy",       32'(busy),       32'd0);
        tick();

        // Zero-length packet: header is also the tail
        flit_ready = 1'b1;
        got_q.delete();
        send_req(8'h2A, 4'd0, w);
        check("t2_req_wait", 32'(w), 32'd0);
        @(negedge CLK);
        check("t2_flit_valid", 32'(flit_valid), 32'd1);
        check("t2_flit_data",  32'(flit_data),  32'h12A);
        wait_idle("t2_idle");
        exp_q = '{9'h12A};
        check_stream("t2_stream");
        check("t2_pkt_count", 32'(pkt_count), 32'd1);
        tick();

        // Three-byte packet followed immediately by another request
        got_q.delete();
        cyc_q.delete();
        send_req(8'h05, 4'd3, w);
        check("t3_req_wait", 32'(w), 32'd0);
        send_pay(8'h11, w);
        check("t3_pay0_wait", 32'(w), 32'd0);
        send_pay(8'h22, w);
        check("t3_pay1_wait", 32'(w), 32'd0);
        send_pay(8'h33, w);
        check("t3_pay2_wait", 32'(w), 32'd0);
        send_req(8'h06, 4'd0, w);
        check("t3_b2b_req_wait", 32'(w), 32'd0);
        wait_idle("t3_idle");
        exp_q = '{9'h005, 9'h011, 9'h022, 9'h133, 9'h106};
        check_stream("t3_stream");
        for (int i = 1; i < 5; i++) begin
            check($sformatf("t3_consecutive_%0d", i),
                  (i < cyc_q.size()) ? 32'(cyc_q[i] - cyc_q[i-1]) : 32'hDEAD_BEEF,
                  32'd1);
        end
        check("t3_pkt_count", 32'(pkt_count), 32'd3);
        tick();

        // Backpressure: FIFO of 4 holds header plus three payload bytes
        flit_ready = 1'b0;
        got_q.delete();
        send_req(8'h07, 4'd7, w);
        send_pay(8'hA0, w);
        send_pay(8'hA1, w);
        send_pay(8'hA2, w);
        check("t4_pay2_wait", 32'(w), 32'd0);
        pay_valid = 1'b1;
        pay_data  = 8'hA3;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check($sformatf("t4_full_pay_ready_%0d", i),  32'(pay_ready),  32'd0);
            check($sformatf("t4_full_req_ready_%0d", i),  32'(req_ready),  32'd0);
            check($sformatf("t4_full_flit_valid_%0d", i), 32'(flit_valid), 32'd1);
            check($sformatf("t4_full_flit_data_%0d", i),  32'(flit_data),  32'h007);
            check($sformatf("t4_full_busy_%0d", i),       32'(busy),       32'd1);
        end
        tick();
        flit_ready = 1'b1;
        send_pay(8'hA3, w);
        send_pay(8'hA4, w);
        send_pay(8'hA5, w);
        send_pay(8'hA6, w);
        wait_idle("t4_idle");
        exp_q = '{9'h007, 9'h0A0, 9'h0A1, 9'h0A2, 9'h0A3, 9'h0A4, 9'h0A5, 9'h1A6};
        check_stream("t4_stream");
        check("t4_pkt_count", 32'(pkt_count), 32'd4);
        tick();

        // Asynchronous reset in the middle of a packet
        flit_ready = 1'b0;
        send_req(8'h08, 4'd5, w);
        send_pay(8'hB0, w);
        send_pay(8'hB1, w);
        @(negedge CLK);
        check("t5_pre_busy", 32'(busy), 32'd1);
        #2;
        RESET = 1'b1;
        #1;
        check("t5_rst_req_ready",  32'(req_ready),  32'd0);
        check("t5_rst_pay_ready",  32'(pay_ready),  32'd0);
        check("t5_rst_flit_valid", 32'(flit_valid), 32'd0);
        check("t5_rst_flit_data",  32'(flit_data),  32'd0);
        check("t5_rst_busy",       32'(busy),       32'd0);
        check("t5_rst_pkt_count",  32'(pkt_count),  32'd0);
        tick();
        RESET = 1'b0;
        @(negedge CLK);
        check("t5_post_req_ready",  32'(req_ready),  32'd1);
        check("t5_post_pay_ready",  32'(pay_ready),  32'd0);
        check("t5_post_flit_valid", 32'(flit_valid), 32'd0);
        check("t5_post_busy",       32'(busy),       32'd0);
        tick();
        flit_ready = 1'b1;
        got_q.delete();
        send_req(8'h01, 4'd1, w);
        send_pay(8'hFF, w);
        wait_idle("t5_idle");
        exp_q = '{9'h001, 9'h1FF};
        check_stream("t5_stream");
        check("t5_pkt_count", 32'(pkt_count), 32'd1);
        tick();

        // Counter wrap
        @(negedge CLK);
        force dut.r_pkt_count = 16'hFFFE;
        #1;
        release dut.r_pkt_count;
        tick();
        send_req(8'h10, 4'd0, w);
        wait_idle("t6_idle_a");
        check("t6_pkt_count_ffff", 32'(pkt_count), 32'h0000_FFFF);
        tick();
        send_req(8'h11, 4'd0, w);
        wait_idle("t6_idle_b");
        check("t6_pkt_count_wrap", 32'(pkt_count), 32'h0000_0000);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
